hop_reset_sequencer: RTL and testbench



---
 rtl/hop_seq_pkg.sv | 16 +
 rtl/hop_seq_gap_counter.sv | 29 ++
 rtl/hop_reset_sequencer.sv | 134 +++++++++++++
 tb/tb_hop_reset_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/hop_seq_pkg.sv
// Shared types and default constants for the hop reset sequencer.
// HOP_SEQ_START_PULSE_EN (see top) enables the start-pulse register.
package hop_seq_pkg;

    localparam int unsigned STATE_W          = 2;
    localparam int unsigned DEF_NUM_STAGES   = 6;
    localparam int unsigned DEF_HOLD_W       = 4;
    localparam int unsigned DEF_DEFAULT_HOLD = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } hop_state_t;

endpackage

// File: rtl/hop_seq_gap_counter.sv
// Loadable HOLD_W-wide down-counter that times the gap between stage releases.
// Load has priority over decrement; zero flags the end of a gap.
module hop_seq_gap_counter #(
    parameter int unsigned      W         = 4,
    parameter logic [W-1:0]     RESET_VAL = '0
) (
    input  logic         clock0,
    input  logic         rst1,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec_en,
    output logic         zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            r_count <= RESET_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec_en) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/hop_reset_sequencer.sv
// Releases per-hop resets upstream to downstream with a programmable gap.
// Define HOP_SEQ_START_PULSE_EN to build the one-cycle start pulse on completion.
module hop_reset_sequencer
    import hop_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = DEF_NUM_STAGES,
    parameter int unsigned HOLD_W       = DEF_HOLD_W,
    parameter int unsigned DEFAULT_HOLD = DEF_DEFAULT_HOLD
) (
    input  logic                  clock0,
    input  logic                  rst1,
    input  logic                  req_reset,
    input  logic [HOLD_W-1:0]     hold_cycles,
    output logic [NUM_STAGES-1:0] rst_stage,
    output logic                  busy,
    output logic                  done,
    output logic                  start_pulse
);

    localparam int unsigned K_W = $clog2(NUM_STAGES + 1);
    localparam logic [HOLD_W-1:0] HOLD_RST = HOLD_W'(DEFAULT_HOLD);

    hop_state_t             r_state, w_state_nxt;
    logic [K_W-1:0]         r_k, w_k_nxt;
    logic [NUM_STAGES-1:0]  r_rst_stage, w_rst_stage_nxt;
    logic [HOLD_W-1:0]      r_hold, w_hold_nxt;
    logic                   r_busy, r_done;
    logic                   w_load, w_dec, w_zero, w_finish;
    logic [HOLD_W-1:0]      w_load_val;

    hop_seq_gap_counter #(
        .W         (HOLD_W),
        .RESET_VAL (HOLD_RST)
    ) u_gap (
        .clock0   (clock0),
        .rst1     (rst1),
        .load     (w_load),
        .load_val (w_load_val),
        .dec_en   (w_dec),
        .zero     (w_zero)
    );

    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            r_state     <= ST_ASSERT;
            r_k         <= '0;
            r_rst_stage <= '1;
            r_hold      <= HOLD_RST;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_rst_stage <= w_rst_stage_nxt;
            r_hold      <= w_hold_nxt;
            r_busy      <= (w_state_nxt != ST_DONE);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k;
        w_rst_stage_nxt = r_rst_stage;
        w_hold_nxt      = r_hold;
        w_load          = 1'b0;
        w_load_val      = r_hold;
        w_dec           = 1'b0;
        w_finish        = 1'b0;
        unique case (r_state)
            ST_ASSERT: begin
                w_dec = 1'b1;
                if (w_zero) begin
                    w_rst_stage_nxt[0] = 1'b0;
                    w_load             = 1'b1;
                    w_k_nxt            = K_W'(1);
                    w_state_nxt        = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_dec = 1'b1;
                if (w_zero) begin
                    if (r_k < K_W'(NUM_STAGES)) begin
                        // Loop-compare keeps the index width-safe for any NUM_STAGES.
                        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                            if (K_W'(i) == r_k) begin
                                w_rst_stage_nxt[i] = 1'b0;
                            end
                        end
                        w_k_nxt = r_k + 1'b1;
                        w_load  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_finish    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (req_reset) begin
                    w_hold_nxt      = hold_cycles;
                    w_load          = 1'b1;
                    w_load_val      = hold_cycles;
                    w_rst_stage_nxt = '1;
                    w_k_nxt         = '0;
                    w_state_nxt     = ST_ASSERT;
                end
            end
            default: begin
                w_state_nxt = ST_ASSERT;
            end
        endcase
    end

    assign rst_stage = r_rst_stage;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef HOP_SEQ_START_PULSE_EN
    logic r_start_pulse;

    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            r_start_pulse <= 1'b0;
        end else begin
            r_start_pulse <= w_finish;
        end
    end

    assign start_pulse = r_start_pulse;
`else
    assign start_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_hop_reset_sequencer.sv
// Directed scoreboard bench: expected per-edge outputs come from the timing
// formulas (stage k low from edge (k+1)(H+1), done from edge (N+1)(H+1)).
module tb_hop_reset_sequencer;

    localparam int unsigned N = 6;
`ifdef HOP_SEQ_START_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    typedef struct {
        int         t;
        logic [5:0] rs;
        logic       busy;
        logic       done;
        logic       sp;
    } exp_t;

    logic       clock0 = 1'b0;
    logic       rst1;
    logic       req_reset;
    logic [3:0] hold_cycles;
    logic [5:0] rst_stage;
    logic       busy, done, start_pulse;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    hop_reset_sequencer #(
        .NUM_STAGES   (6),
        .HOLD_W       (4),
        .DEFAULT_HOLD (3)
    ) dut (
        .clock0      (clock0),
        .rst1        (rst1),
        .req_reset   (req_reset),
        .hold_cycles (hold_cycles),
        .rst_stage   (rst_stage),
        .busy        (busy),
        .done        (done),
        .start_pulse (start_pulse)
    );

    always #5 clock0 = ~clock0;

    // Expected outputs after edge t (t=0 is the accepting edge / reset state).
    task automatic push_seq(input int h, input int ta, input int tb);
        exp_t e;
        int   rel;
        logic [5:0] ones;
        for (int t = ta; t <= tb; t++) begin
            rel = t / (h + 1);
            if (rel > N) rel = N;
            ones   = 6'h3F;
            e.t    = t;
            e.rs   = ones << rel;
            e.done = (t >= (N + 1) * (h + 1));
            e.busy = ~e.done;
            e.sp   = PULSE_EN && (t == (N + 1) * (h + 1));
            sb.push_back(e);
        end
    endtask

    task automatic cmp(input string tag, input int t, input logic [5:0] obs, input logic [5:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp_v);
        end
    endtask

    // One clock: wait for edge, sample 1 time unit later, pop and compare.
    task automatic step();
        exp_t e;
        @(posedge clock0);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=entry");
        end else begin
            e = sb.pop_front();
            cmp("rst_stage",   e.t, rst_stage,          e.rs);
            cmp("busy",        e.t, {5'd0, busy},       {5'd0, e.busy});
            cmp("done",        e.t, {5'd0, done},       {5'd0, e.done});
            cmp("start_pulse", e.t, {5'd0, start_pulse}, {5'd0, e.sp});
        end
    endtask

    task automatic check_reset_state(input string tag);
        cmp({tag, "_rst_stage"}, 0, rst_stage, 6'h3F);
        cmp({tag, "_busy"},      0, {5'd0, busy}, 6'd1);
        cmp({tag, "_done"},      0, {5'd0, done}, 6'd0);
        cmp({tag, "_pulse"},     0, {5'd0, start_pulse}, 6'd0);
    endtask

    initial begin
        rst1        = 1'b1;
        req_reset   = 1'b0;
        hold_cycles = 4'd0;

        // Power-on with defaults
        repeat (2) @(posedge clock0);
        #1;
        check_reset_state("por");
        rst1 = 1'b0;
        push_seq(3, 1, 32);
        repeat (32) step();

        // Request from DONE with H=0
        hold_cycles = 4'd0;
        req_reset   = 1'b1;
        push_seq(0, 0, 10);
        step();
        req_reset = 1'b0;
        repeat (10) step();

        // Request while busy is ignored
        rst1 = 1'b1;
        #2;
        check_reset_state("rst_a");
        rst1 = 1'b0;
        push_seq(3, 1, 30);
        for (int i = 1; i <= 30; i++) begin
            if (i == 10) begin
                req_reset   = 1'b1;
                hold_cycles = 4'd7;
            end
            step();
            req_reset = 1'b0;
        end

        // rst1 mid-sequence
        rst1 = 1'b1;
        #2;
        rst1 = 1'b0;
        push_seq(3, 1, 13);
        repeat (13) step();
        rst1 = 1'b1;
        #1;
        check_reset_state("mid_rst");
        rst1 = 1'b0;
        push_seq(3, 1, 30);
        repeat (30) step();

        // H=15 request, hold_cycles changed mid-sequence
        hold_cycles = 4'd15;
        req_reset   = 1'b1;
        push_seq(15, 0, 115);
        step();
        req_reset = 1'b0;
        for (int i = 1; i <= 115; i++) begin
            if (i == 40) hold_cycles = 4'd1;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
